// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - RV32I opcode constants, encoder request class and field bundle
package instr_enc_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        CLS_R      = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_STORE  = 2'b10,
        CLS_BRANCH = 2'b11
    } enc_class_e;

    typedef struct packed {
        enc_class_e  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [12:0] imm;
    } enc_fields_t;

    // LOAD/STORE immediates must fit 12 signed bits; branch offsets must be even.
    function automatic logic imm_bad(enc_fields_t f);
        logic bad;
        bad = 1'b0;
        if (f.cls == CLS_LOAD || f.cls == CLS_STORE)
            bad = f.imm[12] != f.imm[11];
        else if (f.cls == CLS_BRANCH)
            bad = f.imm[0];
        return bad;
    endfunction

endpackage

// File: rtl/instr_enc_fmt.sv
// rtl/instr_enc_fmt.sv - combinational field-to-word formatter for R/LOAD/STORE/BRANCH
module instr_enc_fmt
    import instr_enc_pkg::*;
(
    input  enc_fields_t fields_i,
    output logic [31:0] instr_o
);

    // Branch offsets are implicitly even, so imm[0] never reaches the word.
    logic unused_imm0;
    assign unused_imm0 = fields_i.imm[0];

    always_comb begin
        instr_o = '0;
        case (fields_i.cls)
            CLS_R:
                instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, fields_i.rd, OP_RTYPE};
            CLS_LOAD:
                instr_o = {fields_i.imm[11:0], fields_i.rs1,
                           fields_i.funct3, fields_i.rd, OP_LOAD};
            CLS_STORE:
                instr_o = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, fields_i.imm[4:0], OP_STORE};
            CLS_BRANCH:
                instr_o = {fields_i.imm[12], fields_i.imm[10:5], fields_i.rs2,
                           fields_i.rs1, fields_i.funct3, fields_i.imm[4:1],
                           fields_i.imm[11], OP_BRANCH};
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I word encoder with output FIFO and address/word counters
// Optional immediate range check enabled by defining ENC_IMM_CHECK_EN.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       word_cnt,
    output logic              imm_err
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    enc_fields_t       fields;
    logic [31:0]       word;
    logic              push, pop, full;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;

    assign fields = '{cls: enc_class_e'(in_class), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    instr_enc_fmt u_fmt (
        .fields_i (fields),
        .instr_o  (word)
    );

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign full      = (count_q == DEPTH_C);
    assign out_valid = (count_q != '0);
    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_addr  = addr_q;
    assign word_cnt  = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            addr_d   = addr_q + ADDR_W'(4);
            cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= ADDR_W'(BASE_ADDR);
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            if (push)
                mem_q[wr_ptr_q] <= word;
        end
    end

`ifdef ENC_IMM_CHECK_EN
    logic err_q, err_d;

    assign err_d   = err_q || (push && imm_bad(fields));
    assign imm_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
`else
    assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - vector table, hand sequences and random model check of instr_encoder
module tb_instr_encoder;

    localparam int ADDR_W = 4;
`ifdef ENC_IMM_CHECK_EN
    localparam bit IMM_CHK = 1'b1;
`else
    localparam bit IMM_CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_class = '0;
    logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]        in_funct3 = '0;
    logic [6:0]        in_funct7 = '0;
    logic [12:0]       in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       word_cnt;
    logic              imm_err;

    int n_checks = 0;
    int n_errors = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .word_cnt(word_cnt), .imm_err(imm_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference encoder: places each field by shifting, from the RV32I layout tables.
    function automatic logic [31:0] ref_enc(input logic [1:0] c, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [12:0] imm);
        int unsigned u, w, common;
        u = imm;
        common = (32'(rs1) << 15) | (32'(f3) << 12);
        case (c)
            2'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | common | (32'(rd) << 7) | 32'h33;
            2'd1: w = ((u & 32'hFFF) << 20) | common | (32'(rd) << 7) | 32'h03;
            2'd2: w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | common
                      | ((u & 32'h1F) << 7) | 32'h23;
            default: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | common | (((u >> 1) & 32'hF) << 8)
                      | (((u >> 11) & 1) << 7) | 32'h63;
        endcase
        return w;
    endfunction

    function automatic bit ref_bad(input logic [1:0] c, input logic [12:0] imm);
        int s;
        s = (imm >= 13'd4096) ? int'(imm) - 8192 : int'(imm);
        if (c == 2'd1 || c == 2'd2) return (s < -2048) || (s > 2047);
        if (c == 2'd3) return (s % 2) != 0;
        return 1'b0;
    endfunction

    task automatic drive(input logic [1:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [12:0] imm);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] imm;
        logic [31:0] exp_instr;
        logic [3:0]  exp_addr;
    } vec_t;

    vec_t         vecs [4];
    logic [31:0]  exp_q [$];
    logic [31:0]  got_instr [$];
    logic [3:0]   got_addr [$];
    logic [31:0]  wa, wb, wc;
    int           exp_addr, exp_cnt;
    bit           err_exp, exp_push, exp_pop;

    initial begin
        vecs[0] = '{2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0,    32'h002081B3, 4'h0};
        vecs[1] = '{2'd1, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 13'd8,    32'h0080A283, 4'h4};
        vecs[2] = '{2'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'd12,   32'h0020A623, 4'h8};
        vecs[3] = '{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8, 32'hFE208CE3, 4'hC};

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        check("rst_imm_err", 32'(imm_err), 0);

        // directed vectors, one word at a time
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i].cls, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3,
                  vecs[i].f7, vecs[i].imm);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1 check($sformatf("vec%0d_no_fallthrough", i), 32'(out_valid), 0);
            cycle();
            in_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_addr", i), 32'(out_addr), 32'(vecs[i].exp_addr));
            cycle();
        end
        check("vec_word_cnt", 32'(word_cnt), 4);

        // backpressure: three requests into a two-entry FIFO
        wa = ref_enc(2'd0, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 13'd0);
        wb = ref_enc(2'd1, 5'd10, 5'd11, 5'd0, 3'd0, 7'd0, 13'h1FFC);
        wc = ref_enc(2'd2, 5'd0, 5'd12, 5'd13, 3'd1, 7'd0, 13'd100);
        out_ready = 1'b0;
        drive(2'd0, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 13'd0);
        in_valid = 1'b1;
        cycle();
        #1 check("bp_ready_after1", 32'(in_ready), 1);
        drive(2'd1, 5'd10, 5'd11, 5'd0, 3'd0, 7'd0, 13'h1FFC);
        cycle();
        drive(2'd2, 5'd0, 5'd12, 5'd13, 3'd1, 7'd0, 13'd100);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready_full", 32'(in_ready), 0);
            check("bp_instr_hold", out_instr, wa);
            check("bp_addr_hold", 32'(out_addr), 0);
            cycle();
        end
        out_ready = 1'b1;
        #1 check("bp_ready_on_pop", 32'(in_ready), 1);
        got_instr.push_back(out_instr);
        got_addr.push_back(out_addr);
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (out_valid) begin
                got_instr.push_back(out_instr);
                got_addr.push_back(out_addr);
            end
            cycle();
        end
        check("bp_word_count", got_instr.size(), 3);
        if (got_instr.size() == 3) begin
            check("bp_w0", got_instr[0], wa);
            check("bp_w1", got_instr[1], wb);
            check("bp_w2", got_instr[2], wc);
            check("bp_a0_wrap", 32'(got_addr[0]), 0);
            check("bp_a1", 32'(got_addr[1]), 4);
            check("bp_a2", 32'(got_addr[2]), 8);
        end
        check("bp_word_cnt", 32'(word_cnt), 7);

        // reset while a word is waiting
        out_ready = 1'b0;
        drive(2'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1 check("mid_valid_before_rst", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_addr", 32'(out_addr), 0);
        check("mid_rst_cnt", 32'(word_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_after_rst_valid", 32'(out_valid), 0);

        // random traffic against the queue model
        exp_addr = 0;
        exp_cnt  = 0;
        err_exp  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                  7'($urandom), 13'($urandom));
            #1;
            check("rnd_in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            check("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("rnd_instr", out_instr, exp_q[0]);
                check("rnd_addr", 32'(out_addr), 32'(exp_addr));
            end
            check("rnd_imm_err", 32'(imm_err), 32'(err_exp));
            exp_push = in_valid && ((exp_q.size() < 2) || out_ready);
            exp_pop  = (exp_q.size() != 0) && out_ready;
            @(posedge clk);
            if (exp_pop) begin
                void'(exp_q.pop_front());
                exp_addr = (exp_addr + 4) % 16;
                exp_cnt++;
            end
            if (exp_push) begin
                exp_q.push_back(ref_enc(in_class, in_rd, in_rs1, in_rs2, in_funct3,
                                        in_funct7, in_imm));
                err_exp = err_exp || (IMM_CHK && ref_bad(in_class, in_imm));
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 check("rnd_word_cnt", 32'(word_cnt), 32'(exp_cnt));
        repeat (3) cycle();

        // immediate range check: LOAD 2048, then BRANCH odd offset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(2'd1, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 13'd2048);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1;
        check("imm_load_2048_err", 32'(imm_err), 32'(IMM_CHK));
        check("imm_load_trunc", out_instr, ref_enc(2'd1, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 13'd2048));
        repeat (3) cycle();
        check("imm_err_sticky", 32'(imm_err), 32'(IMM_CHK));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("imm_err_cleared", 32'(imm_err), 0);
        drive(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1 check("imm_branch_odd_err", 32'(imm_err), 32'(IMM_CHK));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
